// File: rtl/sysarr_matmul_stream.sv
// rtl/sysarr_matmul_stream.sv - DIM x DIM output-stationary systolic signed MAC array with streamed operands
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, k_len, busy     job control; k_len latched (clamped to KMAX) when start is accepted in IDLE
//   in_valid/in_ready      operand beat handshake; a_vec lane i = A[i][k], b_vec lane j = B[k][j]
//   out_valid/out_ready    result row handshake; out_row lane j = C[out_idx][j]
//   done                   one-cycle pulse after the last row is accepted
//   sat_flag               sticky per-job clamp indicator (only with SYSARR_SATURATE_EN)
// Build option: define SYSARR_SATURATE_EN for saturating accumulation (default wraps).
module sysarr_matmul_stream #(
    parameter int DW    = 32,
    parameter int DIM   = 4,
    parameter int KMAX  = 64,
    parameter int ACC_W = 2*DW+6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(KMAX+1)-1:0]  k_len,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW*DIM-1:0]          a_vec,
    input  logic [DW*DIM-1:0]          b_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W*DIM-1:0]       out_row,
    output logic [$clog2(DIM)-1:0]     out_idx,
    output logic                       done
`ifdef SYSARR_SATURATE_EN
    ,
    output logic                       sat_flag
`endif
);
    localparam int KW = $clog2(KMAX+1);
    localparam int IW = $clog2(DIM);
    localparam int FW = $clog2(2*DIM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [KW-1:0]          k_len_q, k_cnt_q, k_clamp;
    logic [FW-1:0]          flush_cnt_q;
    logic                   out_valid_q, done_q;
    logic [IW-1:0]          out_idx_q, row_sel;
    logic [ACC_W*DIM-1:0]   out_row_q, row_next;
    logic                   beat, start_acc, last_row_hs;

    logic signed [DW-1:0]    a_skew [DIM];
    logic signed [DW-1:0]    b_skew [DIM];
    logic                    a_skew_v [DIM];
    logic                    b_skew_v [DIM];
    logic signed [DW-1:0]    a_in [DIM][DIM];
    logic signed [DW-1:0]    b_in [DIM][DIM];
    logic                    av_in [DIM][DIM];
    logic                    bv_in [DIM][DIM];
    logic signed [DW-1:0]    a_pe_q [DIM][DIM];
    logic signed [DW-1:0]    b_pe_q [DIM][DIM];
    logic                    av_q [DIM][DIM];
    logic                    bv_q [DIM][DIM];
    logic signed [ACC_W-1:0] acc_q [DIM][DIM];
    logic signed [ACC_W-1:0] acc_d [DIM][DIM];
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] p_ext;

    assign beat        = (state_q == S_LOAD) && in_valid;
    assign start_acc   = (state_q == S_IDLE) && start;
    assign last_row_hs = (state_q == S_DRAIN) && out_valid_q && out_ready && (out_idx_q == IW'(DIM-1));
    assign k_clamp     = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (k_clamp == '0) ? S_DRAIN : S_LOAD;
            S_LOAD:  if (beat && (k_cnt_q == k_len_q - KW'(1))) state_d = S_FLUSH;
            S_FLUSH: if (flush_cnt_q == FW'(2*DIM-2)) state_d = S_DRAIN;
            S_DRAIN: if (last_row_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Row to load next: row 0 on entering DRAIN, otherwise the row after the one just accepted.
    always_comb begin
        row_sel  = out_valid_q ? (out_idx_q + IW'(1)) : '0;
        row_next = '0;
        for (int j = 0; j < DIM; j++) row_next[j*ACC_W +: ACC_W] = acc_q[row_sel][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            flush_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    k_len_q     <= k_clamp;
                    k_cnt_q     <= '0;
                    flush_cnt_q <= '0;
                    out_idx_q   <= '0;
                    // Empty job: accumulators are being cleared, so row 0 is known to be zero now.
                    if (k_clamp == '0) begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                    end
                end
                S_LOAD:  if (beat) k_cnt_q <= k_cnt_q + KW'(1);
                S_FLUSH: flush_cnt_q <= flush_cnt_q + FW'(1);
                S_DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= row_next;
                    end else if (out_ready) begin
                        if (out_idx_q == IW'(DIM-1)) begin
                            out_valid_q <= 1'b0;
                            out_idx_q   <= '0;
                            out_row_q   <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            out_idx_q <= out_idx_q + IW'(1);
                            out_row_q <= row_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Input skew: lane n passes through n registers before entering the array edge.
    for (genvar gn = 0; gn < DIM; gn++) begin : g_skew
        if (gn == 0) begin : g_direct
            assign a_skew[gn]   = a_vec[gn*DW +: DW];
            assign b_skew[gn]   = b_vec[gn*DW +: DW];
            assign a_skew_v[gn] = beat;
            assign b_skew_v[gn] = beat;
        end else begin : g_delay
            logic signed [DW-1:0] ad_q [gn];
            logic signed [DW-1:0] bd_q [gn];
            logic                 v_q  [gn];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < gn; s++) begin
                        ad_q[s] <= '0;
                        bd_q[s] <= '0;
                        v_q[s]  <= 1'b0;
                    end
                end else begin
                    ad_q[0] <= a_vec[gn*DW +: DW];
                    bd_q[0] <= b_vec[gn*DW +: DW];
                    v_q[0]  <= beat;
                    for (int s = 1; s < gn; s++) begin
                        ad_q[s] <= ad_q[s-1];
                        bd_q[s] <= bd_q[s-1];
                        v_q[s]  <= v_q[s-1];
                    end
                end
            end
            assign a_skew[gn]   = ad_q[gn-1];
            assign b_skew[gn]   = bd_q[gn-1];
            assign a_skew_v[gn] = v_q[gn-1];
            assign b_skew_v[gn] = v_q[gn-1];
        end
    end

    // Array wiring: a enters at column 0 and moves right, b enters at row 0 and moves down.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj]  = a_skew[gi];
                assign av_in[gi][gj] = a_skew_v[gi];
            end else begin : g_a_link
                assign a_in[gi][gj]  = a_pe_q[gi][gj-1];
                assign av_in[gi][gj] = av_q[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj]  = b_skew[gj];
                assign bv_in[gi][gj] = b_skew_v[gj];
            end else begin : g_b_link
                assign b_in[gi][gj]  = b_pe_q[gi-1][gj];
                assign bv_in[gi][gj] = bv_q[gi-1][gj];
            end
        end
    end

`ifdef SYSARR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] sum_x;
    logic                  sat_any, sat_q;
    assign sat_flag = sat_q;
`endif

    always_comb begin
        prod  = '0;
        p_ext = '0;
`ifdef SYSARR_SATURATE_EN
        sum_x   = '0;
        sat_any = 1'b0;
`endif
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                prod  = (2*DW)'(a_pe_q[i][j]) * (2*DW)'(b_pe_q[i][j]);
                p_ext = ACC_W'(prod);
`ifdef SYSARR_SATURATE_EN
                // One guard bit exposes signed overflow of the add.
                sum_x = (ACC_W+1)'(acc_q[i][j]) + (ACC_W+1)'(p_ext);
                if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
                    acc_d[i][j] = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
                    if (av_q[i][j] && bv_q[i][j]) sat_any = 1'b1;
                end else begin
                    acc_d[i][j] = sum_x[ACC_W-1:0];
                end
`else
                acc_d[i][j] = acc_q[i][j] + p_ext;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    av_q[i][j]   <= 1'b0;
                    bv_q[i][j]   <= 1'b0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    a_pe_q[i][j] <= a_in[i][j];
                    b_pe_q[i][j] <= b_in[i][j];
                    av_q[i][j]   <= av_in[i][j];
                    bv_q[i][j]   <= bv_in[i][j];
                    if (start_acc)
                        acc_q[i][j] <= '0;
                    else if (av_q[i][j] && bv_q[i][j] && (state_q != S_DRAIN))
                        acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

`ifdef SYSARR_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= 1'b0;
        else if (start_acc)
            sat_q <= 1'b0;
        else if (sat_any && (state_q != S_DRAIN))
            sat_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sysarr_matmul_stream.sv
// tb/tb_sysarr_matmul_stream.sv - directed table-driven bench for sysarr_matmul_stream
module tb_sysarr_matmul_stream;
    localparam int DW    = 32;
    localparam int DIM   = 4;
    localparam int KMAX  = 64;
    localparam int ACC_W = 2*DW+6;
    localparam int KW    = $clog2(KMAX+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW*DIM-1:0]      a_vec;
    logic [DW*DIM-1:0]      b_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W*DIM-1:0]   out_row;
    logic [$clog2(DIM)-1:0] out_idx;
    logic                   done;
`ifdef SYSARR_SATURATE_EN
    logic                   sat_flag;
`endif

    always #5 clk = ~clk;

    sysarr_matmul_stream #(.DW(DW), .DIM(DIM), .KMAX(KMAX), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .done(done)
`ifdef SYSARR_SATURATE_EN
        , .sat_flag(sat_flag)
`endif
    );

    typedef struct {
        int k;
        bit bub;
        int a [4][4];
        int b [4][4];
        int c [4][4];
    } vec_t;

    vec_t tv [4];
    vec_t zv;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [DW*DIM-1:0] pack(input int l [4]);
        logic [DW*DIM-1:0] p;
        for (int i = 0; i < DIM; i++) p[i*DW +: DW] = l[i];
        return p;
    endfunction

    // Called at a negedge; returns at the negedge in which done is asserted.
    task automatic run_job(input vec_t v, input int stall_row, input bit mid_start);
        int beat, cyc, lat, t;
        logic [ACC_W*DIM-1:0] held_row;
        logic [$clog2(DIM)-1:0] held_idx;
        logic signed [ACC_W-1:0] e;
        start = 1'b1;
        k_len = KW'(v.k);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        beat = 0;
        cyc  = 0;
        while (beat < v.k && cyc < 200) begin
            chk("in_ready_load", in_ready, 1);
            in_valid = v.bub ? (cyc % 3 == 0) : 1'b1;
            a_vec = pack(v.a[beat]);
            b_vec = pack(v.b[beat]);
            @(negedge clk);
            if (in_valid) beat++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("in_ready_after_last", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (v.k == 0) ? 0 : 2*DIM);
        for (int r = 0; r < DIM; r++) begin
            t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("row_valid", out_valid, 1);
            chk("done_early", done, 0);
            chk("busy_drain", busy, 1);
            chk("out_idx", out_idx, r);
            for (int j = 0; j < DIM; j++) begin
                e = v.c[r][j];
                chk("out_lane", out_row[j*ACC_W +: ACC_W], e);
            end
            if (r == stall_row) begin
                out_ready = 1'b0;
                held_row  = out_row;
                held_idx  = out_idx;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_idx", out_idx, held_idx);
                    chk("stall_row", out_row == held_row, 1);
                    chk("stall_done", done, 0);
                end
                out_ready = 1'b1;
            end
            if (mid_start && r == 2) begin
                start = 1'b1;
                k_len = KW'(3);
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("out_valid_at_done", out_valid, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                tv[0].a[k][l] = (k == l) ? 1 : 0;
                tv[0].b[k][l] = 10*k + l;
                tv[0].c[k][l] = 10*k + l;
            end
        end
        tv[0].k = 4;  tv[0].bub = 1'b0;
        tv[1].k = 1;  tv[1].bub = 1'b0;
        tv[1].a[0] = '{1, 2, 3, 4};
        tv[1].b[0] = '{-1, 5, 0, 7};
        tv[1].c    = '{'{-1, 5, 0, 7}, '{-2, 10, 0, 14}, '{-3, 15, 0, 21}, '{-4, 20, 0, 28}};
        tv[2].k = 2;  tv[2].bub = 1'b0;
        tv[2].a[0] = '{1, -1, 2, 0};
        tv[2].a[1] = '{3, 1, -2, 5};
        tv[2].b[0] = '{1, 2, 3, 4};
        tv[2].b[1] = '{-1, 0, 1, 2};
        tv[2].c    = '{'{-2, 2, 6, 10}, '{-2, -2, -2, -2}, '{4, 4, 4, 4}, '{-5, 0, 5, 10}};
        tv[3] = tv[0];
        tv[3].bub = 1'b1;
        zv.k = 0;     zv.bub = 1'b0;

        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_vec = '0; b_vec = '0; out_ready = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row == '0, 1);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back jobs: each next start lands in the done cycle of the previous one.
        run_job(tv[0], -1, 1'b0);
        run_job(tv[1], -1, 1'b0);
        run_job(tv[3],  1, 1'b0);
        run_job(tv[2], -1, 1'b0);
        run_job(zv,    -1, 1'b1);

        // Abort mid-LOAD after two beats, then a fresh job must be unaffected.
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(4);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            a_vec = pack(tv[0].a[b]);
            b_vec = pack(tv[2].b[b]);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_row", out_row == '0, 1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        run_job(tv[2], -1, 1'b0);

        @(negedge clk);
        chk("done_single_cycle", done, 0);
        chk("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
